// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional perf counters are enabled with FETCH_CTRL_PERF_EN.
package fetch_ctrl_pkg;
   localparam logic RST_ENABLE   = 1'b1;
   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;
   localparam int   INST_ADDR_W  = 32;
   localparam int   INST_W       = 32;

   typedef logic [INST_ADDR_W-1:0] addr_t;
   typedef logic [INST_W-1:0]      inst_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      HOLD  = 2'b10
   } state_t;

   typedef struct packed {
      logic  valid;
      addr_t pc;
      inst_t inst;
   } if_id_t;

   function automatic addr_t word_align(input addr_t a);
      return a & ~addr_t'(3);
   endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: execute redirect, imem handshake, IF/ID payload.
// Perf counter signals exist only with FETCH_CTRL_PERF_EN.
interface fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic  stall_i;
   logic  branch_flag_i;
   addr_t branch_target_i;
   logic  imem_ack_i;
   inst_t imem_inst_i;
   logic  ce_o;
   addr_t pc_o;
   logic  imem_req_o;
   logic  if_valid_o;
   addr_t if_pc_o;
   inst_t if_inst_o;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   modport master (
      input  stall_i, branch_flag_i, branch_target_i,
      input  imem_ack_i, imem_inst_i,
      output ce_o, pc_o, imem_req_o,
      output if_valid_o, if_pc_o, if_inst_o
`ifdef FETCH_CTRL_PERF_EN
      , output fetch_cnt_o, flush_cnt_o
`endif
   );

   modport slave (
      output stall_i, branch_flag_i, branch_target_i,
      output imem_ack_i, imem_inst_i,
      input  ce_o, pc_o, imem_req_o,
      input  if_valid_o, if_pc_o, if_inst_o
`ifdef FETCH_CTRL_PERF_EN
      , input fetch_cnt_o, flush_cnt_o
`endif
   );
endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching an ack that arrives while decode stalls.
module fetch_skid
   import fetch_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   clear,
   input  addr_t  pc,
   input  inst_t  inst,
   output if_id_t q
);
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE || clear) begin
         q <= '0;
      end else if (load) begin
         q <= '{valid: 1'b1, pc: pc, inst: inst};
      end
   end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: imem request/ack, redirect kill, IF/ID skid.
// Define FETCH_CTRL_PERF_EN to add fetch/flush counters.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.master bus
);
   state_t state, state_n;
   addr_t  pc_q;
   logic   outst, kill;
   if_id_t out_q, skid;
   logic   stall, req, acc, redir, use_ack, slot_free;
   logic   skid_ld, skid_clr, skid_pop;

   assign stall     = bus.stall_i;
   assign req       = (state == FETCH) & (outst | ~(stall & out_q.valid));
   assign acc       = (state == FETCH) & bus.imem_ack_i;
   assign redir     = (state != IDLE) & bus.branch_flag_i;
   assign use_ack   = acc & ~kill & ~redir;
   assign slot_free = ~out_q.valid | ~stall;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) state <= IDLE;
      else                   state <= state_n;
   end

   always_comb begin
      state_n  = state;
      skid_ld  = 1'b0;
      skid_clr = 1'b0;
      skid_pop = 1'b0;
      unique case (state)
         IDLE: state_n = FETCH;
         FETCH: begin
            if (redir) begin
               skid_clr = 1'b1;
            end else if (use_ack & ~slot_free) begin
               skid_ld = 1'b1;
               state_n = HOLD;
            end
         end
         HOLD: begin
            if (redir) begin
               skid_clr = 1'b1;
               state_n  = FETCH;
            end else if (~stall) begin
               skid_pop = 1'b1;
               skid_clr = 1'b1;
               state_n  = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A redirect with the old request still in flight must drop its ack
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         pc_q  <= '0;
         outst <= 1'b0;
         kill  <= 1'b0;
         out_q <= '0;
      end else if (redir) begin
         pc_q        <= word_align(bus.branch_target_i);
         outst       <= req & ~bus.imem_ack_i;
         kill        <= req & ~bus.imem_ack_i;
         out_q.valid <= 1'b0;
      end else begin
         outst <= req & ~bus.imem_ack_i;
         if (acc) kill <= 1'b0;
         if (use_ack) pc_q <= pc_q + 32'd4;
         if (use_ack & slot_free) begin
            out_q <= '{valid: 1'b1, pc: pc_q, inst: bus.imem_inst_i};
         end else if (skid_pop) begin
            out_q <= skid;
         end else if (~stall) begin
            out_q.valid <= 1'b0;
         end
      end
   end

   fetch_skid u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_ld),
      .clear (skid_clr),
      .pc    (pc_q),
      .inst  (bus.imem_inst_i),
      .q     (skid)
   );

   assign bus.ce_o       = (state != IDLE) ? CHIP_ENABLE : CHIP_DISABLE;
   assign bus.pc_o       = pc_q;
   assign bus.imem_req_o = req;
   assign bus.if_valid_o = out_q.valid;
   assign bus.if_pc_o    = out_q.pc;
   assign bus.if_inst_o  = out_q.inst;

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] fetch_cnt, flush_cnt;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (use_ack) fetch_cnt <= fetch_cnt + 32'd1;
         if (redir)   flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign bus.fetch_cnt_o = fetch_cnt;
   assign bus.flush_cnt_o = flush_cnt;
`endif
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high (`RstEnable = 1'b1`).
REQ-003 stall_i  input  1  decode stage cannot accept if_* this cycle.
REQ-004 branch_flag_i  input  1  one-cycle redirect request from execute.
REQ-005 branch_target_i  input  32  redirect address; bits [1:0] ignored, forced to 00.
REQ-006 imem_ack_i  input  1  instruction memory returns data for the current request.
REQ-007 imem_inst_i  input  32  instruction data, valid when imem_ack_i=1.
REQ-008 ce_o  output  1  instruction memory chip enable.
REQ-009 pc_o  output  32  address of the next or outstanding fetch; also drives the memory address.
REQ-010 imem_req_o  output  1  fetch request; once raised, held until imem_ack_i.
REQ-011 if_valid_o / if_pc_o / if_inst_o  output  1/32/32  IF/ID payload: valid flag, instruction address, instruction word.

Function
REQ-012 States: IDLE, FETCH and HOLD; encodings are defined in defines.v.
REQ-013 IDLE:
- ce_o=0 and imem_req_o=0.
- Transitions to FETCH on the first clk edge with rst=0.
- ce_o=1 from that edge onward.
REQ-014 Outstanding flag:
- Set when imem_req_o=1 and imem_ack_i=0.
- Cleared on imem_ack_i.
REQ-015 In FETCH, imem_req_o = outstanding | ~(stall_i & if_valid_o).
- A request is never dropped before its ack.
- imem_req_o is 0 in IDLE and HOLD.
REQ-016 FETCH, ack with no kill pending:
- Output slot free (if_valid_o=0 or stall_i=0): load if_pc_o<=pc_o, if_inst_o<=imem_inst_i and if_valid_o<=1.
- Output slot occupied (if_valid_o=1 and stall_i=1): load the skid buffer and go to HOLD.
- In both cases pc_o<=pc_o+4.
REQ-017 Ack latency is 0..N cycles. A same-cycle ack (req and ack in one cycle) is legal, giving one instruction per cycle.
REQ-018 If stall_i=0, no ack arrives and no new payload is loaded, then if_valid_o<=0.
REQ-019 HOLD:
- Output payload is held while stall_i=1.
- When stall_i=0: output<=skid, skid cleared, go to FETCH.
REQ-020 Redirect (branch_flag_i=1) has highest priority in any non-IDLE state and overrides stall_i:
- pc_o<=branch_target_i & ~3, if_valid_o<=0, skid cleared, state<=FETCH.
REQ-021 Redirect while a request is outstanding and the ack does not arrive in the same cycle: set kill.
- The next ack is discarded and clears kill.
- pc_o is not incremented by the discarded ack.
REQ-022 Redirect in the same cycle as an ack: the acked instruction is discarded and kill is not set.
REQ-023 pc_o arithmetic is 32-bit modulo: 0xFFFFFFFC+4 = 0x00000000.
REQ-024 The payload is valid while if_valid_o=1 and transfers to decode when stall_i=0.

Reset
REQ-025 rst=1 at any edge, including mid-fetch, produces:
- state=IDLE, ce_o=0, pc_o=0, imem_req_o=0.
- if_valid_o=0, if_pc_o=0, if_inst_o=0.
- outstanding=0, kill=0, skid empty, perf counters 0.
REQ-026 An imem_ack_i received while in IDLE is ignored.

Configuration
REQ-027 Macro FETCH_CTRL_PERF_EN.
- Defined: adds 32-bit outputs fetch_cnt_o and flush_cnt_o, both reset to 0 and wrapping at 2^32.
- fetch_cnt_o counts +1 per accepted, non-discarded ack.
- flush_cnt_o counts +1 per redirect cycle.
- Undefined: both ports and all counter logic are absent; all other behaviour is identical.

Structure
REQ-028 defines.v holds: state encodings, `RstEnable`, `ChipEnable`/`ChipDisable`, `InstAddrBus`, `InstBus`.
REQ-029 The one-entry skid buffer (valid, pc, inst, with load/clear/hold) is a sub-module named fetch_skid.

Verification
REQ-030 Reset release with ack tied high: ce_o=1 one edge after rst falls. if_pc_o then sequences 0,4,8,... one per cycle, and if_valid_o stays at 1.
REQ-031 Ack delayed 3 cycles: imem_req_o stays 1 for 4 cycles with pc_o stable; then if_valid_o=1 and pc_o advances by 4.
REQ-032 stall_i=1 for 5 cycles with if_valid_o=1 and an ack arriving: that ack lands in skid and state goes to HOLD. On stall release, the skid payload is output, with no instruction lost or duplicated.
REQ-033 Redirect to 0x00000103 while a request is outstanding:
- pc_o=0x00000100.
- The next ack is discarded and if_valid_o stays 0.
- The next payload has if_pc_o=0x100.
- flush_cnt_o=1 when perf is enabled.
REQ-034 pc_o=0xFFFFFFFC with an ack: pc_o wraps to 0x00000000.
REQ-035 rst asserted mid-wait (req=1, no ack): next edge gives all outputs 0. A late ack in IDLE produces no payload.
